// File: rtl/mdr_result_reader_pkg.sv
// Shared MDR types plus the result reader's state encoding, header field
// layout and per-operation payload word counts.
package pkg_system_mdr;

  localparam int DATA_W = 16;
  typedef logic [DATA_W-1:0] data_t;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_DIV   = 2'b01,
    OP_ROOT  = 2'b10,
    OP_UNDEF = 2'b11
  } op_t;

  typedef enum logic [1:0] {
    IDLE,
    HEADER,
    PAYLOAD
  } rd_state_t;

  // Header layout, positions counted down from the word MSB so they scale with DW:
  // error at MSB, op field directly below it, payload count in the low bits.
  localparam int HDR_ERR_FROM_MSB = 0;
  localparam int HDR_OP_FROM_MSB  = 1;
  localparam int HDR_OP_W         = 2;
  localparam int HDR_CNT_W        = 4;

  // Payload words following the header for each operation.
  localparam logic [HDR_CNT_W-1:0] CNT_MULT = 4'd2;  // result LSW, MSW
  localparam logic [HDR_CNT_W-1:0] CNT_DIV  = 4'd4;  // quotient LSW, MSW, remainder LSW, MSW
  localparam logic [HDR_CNT_W-1:0] CNT_ROOT = 4'd2;  // result LSW, remainder LSW
  localparam logic [HDR_CNT_W-1:0] CNT_NONE = 4'd0;  // error or undefined op

endpackage

// File: rtl/mdr_result_reader_if.sv
// Word stream out of the result reader: valid/ready handshake with last marker.
interface mdr_result_reader_if #(
  parameter int DW = 16
);
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;

  modport master (output out_valid, output out_data, output out_last, input out_ready);
  modport slave  (input out_valid, input out_data, input out_last, output out_ready);
endinterface

// File: rtl/mdr_result_reader.sv
// Captures a finished MDR operation and serialises it as a header word
// followed by 0/2/4 payload words. A result arriving while a packet is still
// in flight is dropped and flagged in the sticky overrun bit, except in the
// cycle the final word leaves, where it is taken back-to-back.
module mdr_result_reader
  import pkg_system_mdr::*;
#(
  parameter int DW = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                mdr_ready,
  input  logic                mdr_error,
  input  op_t                 mdr_op,
  input  logic [2*DW-1:0]     mdr_result,
  input  logic [2*DW-1:0]     mdr_remainder,
  input  logic                clean,
  mdr_result_reader_if.master out_if,
  output logic                busy,
  output logic                overrun
);

  localparam int ERR_BIT = DW - 1 - HDR_ERR_FROM_MSB;
  localparam int OP_MSB  = DW - 1 - HDR_OP_FROM_MSB;

  rd_state_t             state;
  logic [HDR_CNT_W-1:0]  cnt;
  logic                  cap_err;
  op_t                   cap_op;
  logic [2*DW-1:0]       cap_res;
  logic [2*DW-1:0]       cap_rem;

  logic [HDR_CNT_W-1:0]  n_cur;
  logic [HDR_CNT_W-1:0]  cnt_nxt;
  logic                  last;
  logic                  xfer;
  logic                  accept;
  logic                  drop;

  function automatic logic [HDR_CNT_W-1:0] pay_cnt(input logic err, input op_t op);
    if (err) return CNT_NONE;
    case (op)
      OP_MULT: return CNT_MULT;
      OP_DIV:  return CNT_DIV;
      OP_ROOT: return CNT_ROOT;
      default: return CNT_NONE;
    endcase
  endfunction

  function automatic logic [DW-1:0] hdr_word(input logic err, input op_t op,
                                             input logic [HDR_CNT_W-1:0] n);
    logic [DW-1:0] h;
    h                       = '0;
    h[ERR_BIT]              = err;
    h[OP_MSB -: HDR_OP_W]   = op;
    h[HDR_CNT_W-1:0]        = n;
    return h;
  endfunction

  function automatic logic [DW-1:0] pay_word(input op_t op, input logic [HDR_CNT_W-1:0] idx,
                                             input logic [2*DW-1:0] res,
                                             input logic [2*DW-1:0] rem);
    case (op)
      OP_DIV: begin
        case (idx)
          4'd0:    return res[DW-1:0];
          4'd1:    return res[2*DW-1:DW];
          4'd2:    return rem[DW-1:0];
          default: return rem[2*DW-1:DW];
        endcase
      end
      OP_ROOT: return (idx == 4'd0) ? res[DW-1:0] : rem[DW-1:0];
      default: return (idx == 4'd0) ? res[DW-1:0] : res[2*DW-1:DW];
    endcase
  endfunction

  // Output word, last marker and handshake decode, all derived from registers
  // only, so they stay stable while the consumer stalls.
  always_comb begin
    n_cur            = pay_cnt(cap_err, cap_op);
    cnt_nxt          = cnt + 4'd1;
    last             = ((state == HEADER) && (n_cur == CNT_NONE)) ||
                       ((state == PAYLOAD) && (cnt_nxt == n_cur));
    out_if.out_valid = (state != IDLE);
    out_if.out_last  = last;
    case (state)
      HEADER:  out_if.out_data = hdr_word(cap_err, cap_op, n_cur);
      PAYLOAD: out_if.out_data = pay_word(cap_op, cnt, cap_res, cap_rem);
      default: out_if.out_data = '0;
    endcase
    xfer   = out_if.out_valid && out_if.out_ready;
    accept = mdr_ready && ((state == IDLE) || (xfer && last));
    drop   = mdr_ready && !accept;
  end

  assign busy = (state != IDLE);

  // Packet FSM: capture on accept, then walk header and payload words per transfer.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      cnt     <= '0;
      cap_err <= 1'b0;
      cap_op  <= OP_MULT;
      cap_res <= '0;
      cap_rem <= '0;
    end else if (accept) begin
      state   <= HEADER;
      cnt     <= '0;
      cap_err <= mdr_error;
      cap_op  <= mdr_op;
      cap_res <= mdr_result;
      cap_rem <= mdr_remainder;
    end else begin
      case (state)
        HEADER: if (xfer) begin
          state <= (n_cur == CNT_NONE) ? IDLE : PAYLOAD;
          cnt   <= '0;
        end
        PAYLOAD: if (xfer) begin
          if (last) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt   <= cnt_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  // Sticky overrun; a drop in the same cycle as clean wins.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)       overrun <= 1'b0;
    else if (drop)  overrun <= 1'b1;
    else if (clean) overrun <= 1'b0;
  end

endmodule

// File: tb/tb_mdr_result_reader.sv
// Randomized + directed bench for mdr_result_reader with a queue scoreboard.
module tb_mdr_result_reader;
  import pkg_system_mdr::*;

  localparam int DW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mdr_ready = 1'b0;
  logic        mdr_error = 1'b0;
  op_t         mdr_op = OP_MULT;
  logic [31:0] mdr_result = '0;
  logic [31:0] mdr_remainder = '0;
  logic        clean = 1'b0;
  logic        busy, overrun;

  mdr_result_reader_if #(.DW(DW)) out_if();

  mdr_result_reader #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .mdr_ready(mdr_ready), .mdr_error(mdr_error),
    .mdr_op(mdr_op), .mdr_result(mdr_result), .mdr_remainder(mdr_remainder),
    .clean(clean), .out_if(out_if), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int          n_chk = 0;
  int          n_err = 0;
  logic [16:0] exp_q[$];    // {last, data}
  logic [16:0] forced[$];   // literal expectations for the next accepted packet
  int          pending = 0; // words of the current packet not yet transferred
  logic        ovr_m = 1'b0;
  logic        busy_exp = 1'b0;
  logic        ovr_exp = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] isqrt(input logic [31:0] a);
    logic [63:0] r, t;
    r = 0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (64'd1 << b);
      if (t * t <= {32'd0, a}) r = t;
    end
    return r[31:0];
  endfunction

  // Reference packet from the format rules: header then payload words.
  task automatic push_pkt(input logic err, input op_t op, input logic [31:0] res,
                          input logic [31:0] rem);
    logic [15:0] w[$];
    int n;
    if (forced.size() > 0) begin
      pending = forced.size();
      foreach (forced[i]) exp_q.push_back(forced[i]);
      forced.delete();
      return;
    end
    if (err || op == OP_UNDEF) n = 0;
    else if (op == OP_DIV)     n = 4;
    else                       n = 2;
    w.push_back({err, op, 9'd0, 4'(n)});
    if (n > 0) begin
      w.push_back(res[15:0]);
      if (op == OP_MULT) w.push_back(res[31:16]);
      if (op == OP_DIV) begin
        w.push_back(res[31:16]);
        w.push_back(rem[15:0]);
        w.push_back(rem[31:16]);
      end
      if (op == OP_ROOT) w.push_back(rem[15:0]);
    end
    foreach (w[i]) exp_q.push_back({(i == w.size() - 1) ? 1'b1 : 1'b0, w[i]});
    pending = w.size();
  endtask

  // One clock: drive inputs just after the edge, then advance the model to
  // what the next edge must do with them.
  task automatic step(input logic rdy, input logic err, input op_t op,
                      input logic [31:0] res, input logic [31:0] rem,
                      input logic ordy, input logic cln);
    logic xf, fin, acc;
    @(posedge clk);
    #1;
    busy_exp = (pending != 0);
    ovr_exp  = ovr_m;
    mdr_ready = rdy; mdr_error = err; mdr_op = op;
    mdr_result = res; mdr_remainder = rem;
    out_if.out_ready = ordy; clean = cln;
    xf  = (pending != 0) && ordy;
    fin = xf && (pending == 1);
    acc = rdy && ((pending == 0) || fin);
    if (rdy && !acc) begin
      ovr_m = 1'b1;
      forced.delete();
    end else if (cln) ovr_m = 1'b0;
    if (xf) pending--;
    if (acc) push_pkt(err, op, res, rem);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b0);
  endtask

  task automatic drain();
    int g;
    g = 0;
    while (pending != 0 && g < 60) begin
      step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b0);
      g++;
    end
    idle(2);
    @(negedge clk);
    chk("drain_pending", 32'(pending), 32'd0);
    chk("drain_queue", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic rand_step();
    logic        rdy, err, ordy, cln;
    op_t         op;
    logic [31:0] a, b, res, rem;
    rdy  = ($urandom_range(0, 5) == 0);
    err  = ($urandom_range(0, 7) == 0);
    op   = op_t'($urandom_range(0, 3));
    ordy = ($urandom_range(0, 3) != 0);
    cln  = ($urandom_range(0, 19) == 0);
    case (op)
      OP_MULT: begin
        a = $urandom_range(0, 65535); b = $urandom_range(0, 65535);
        res = a * b; rem = 0;
      end
      OP_DIV: begin
        a = $urandom; b = $urandom_range(1, 65535);
        res = a / b; rem = a % b;
      end
      OP_ROOT: begin
        a = $urandom; res = isqrt(a); rem = a - res * res;
      end
      default: begin
        res = $urandom; rem = $urandom;
      end
    endcase
    step(rdy, err, op, res, rem, ordy, cln);
  endtask

  // Monitor: per-cycle status checks, hold-while-stalled, and word scoreboard.
  initial begin
    logic        hv;
    logic [16:0] prev, e;
    hv = 1'b0; prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hv = 1'b0;
        continue;
      end
      chk("busy", 32'(busy), 32'(busy_exp));
      chk("overrun", 32'(overrun), 32'(ovr_exp));
      chk("out_valid", 32'(out_if.out_valid), 32'(busy_exp));
      if (hv) chk("hold_stable", 32'({out_if.out_last, out_if.out_data}), 32'(prev));
      hv   = out_if.out_valid && !out_if.out_ready;
      prev = {out_if.out_last, out_if.out_data};
      if (out_if.out_valid && out_if.out_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++; n_err++;
          $display("FAIL unexpected_word: got %h expected none at %0t",
                   {out_if.out_last, out_if.out_data}, $time);
        end else begin
          e = exp_q.pop_front();
          chk("word", 32'({out_if.out_last, out_if.out_data}), 32'(e));
        end
      end
    end
  end

  initial begin
    out_if.out_ready = 1'b0;
    #3;
    chk("rst_valid", 32'(out_if.out_valid), 32'd0);
    chk("rst_last", 32'(out_if.out_last), 32'd0);
    chk("rst_data", 32'(out_if.out_data), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // MULT 300*500
    forced = {17'h00002, 17'h049F0, 17'h10002};
    step(1'b1, 1'b0, OP_MULT, 32'd150000, 32'd0, 1'b0, 1'b0);
    drain();

    // DIV 1000/7
    forced = {17'h02004, 17'h0008E, 17'h00000, 17'h00006, 17'h10000};
    step(1'b1, 1'b0, OP_DIV, 32'h8E, 32'd6, 1'b1, 1'b0);
    drain();

    // ROOT 100 with a 3-cycle stall on the first payload word
    forced = {17'h04002, 17'h0000A, 17'h10000};
    step(1'b1, 1'b0, OP_ROOT, 32'd10, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
    drain();

    // DIV with error: header-only packet
    forced = {17'h1A000};
    step(1'b1, 1'b1, OP_DIV, 32'h1234, 32'h5678, 1'b1, 1'b0);
    drain();

    // Drop during HEADER, clean, then back-to-back accept on final transfer
    step(1'b1, 1'b0, OP_MULT, 32'h12345678, 32'd0, 1'b0, 1'b0);
    step(1'b1, 1'b0, OP_ROOT, 32'd3, 32'd1, 1'b0, 1'b0);
    step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b0);
    step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b0, 1'b1);
    begin
      int g;
      g = 0;
      while (pending != 1 && g < 20) begin
        step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b0);
        g++;
      end
      chk("reach_final_word", 32'(pending), 32'd1);
    end
    step(1'b1, 1'b0, OP_DIV, 32'h0001_0002, 32'h0003_0004, 1'b1, 1'b0);
    drain();

    // Randomized traffic
    for (int i = 0; i < 800; i++) rand_step();
    drain();

    // Asynchronous reset in the middle of a payload
    step(1'b1, 1'b0, OP_DIV, 32'hAAAA_5555, 32'h0F0F_F0F0, 1'b0, 1'b0);
    step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b0);
    step(1'b0, 1'b0, OP_MULT, 32'd0, 32'd0, 1'b1, 1'b0);
    rst = 1'b0;
    #1;
    chk("arst_valid", 32'(out_if.out_valid), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_last", 32'(out_if.out_last), 32'd0);
    chk("arst_data", 32'(out_if.out_data), 32'd0);
    exp_q.delete(); forced.delete();
    pending = 0; ovr_m = 1'b0; busy_exp = 1'b0; ovr_exp = 1'b0;
    mdr_ready = 1'b0; out_if.out_ready = 1'b0; clean = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    step(1'b1, 1'b0, OP_MULT, 32'hBEEF_CAFE, 32'd0, 1'b1, 1'b0);
    drain();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/mdr_result_reader.md
MDR_RESULT_READER -- requirements
Module: mdr_result_reader

Interface
REQ-001 SHALL take parameter DW, default 16, the MDR operand width; output word width is DW and captured result/remainder width is 2*DW.
REQ-002 SHALL have clk  input  1  single system clock; all logic rising-edge.
REQ-003 SHALL have rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have mdr_ready  input  1  one-cycle pulse from the MDR core marking a finished operation.
REQ-005 SHALL have mdr_error  input  1  error flag from the core, valid with mdr_ready.
REQ-006 SHALL have mdr_op  input  2  op_t of the finished operation, valid with mdr_ready.
REQ-007 SHALL have mdr_result  input  2*DW  product/quotient/root, valid with mdr_ready.
REQ-008 SHALL have mdr_remainder  input  2*DW  remainder, valid with mdr_ready.
REQ-009 SHALL have clean  input  1  synchronous clear of the sticky overrun flag.
REQ-010 SHALL have out_ready  input  1  downstream accepts a word.
REQ-011 SHALL have out_valid  output  1  out_data holds a word.
REQ-012 SHALL have out_data  output  DW  header or payload word.
REQ-013 SHALL have out_last  output  1  current word is the final word of the packet.
REQ-014 SHALL have busy  output  1  a packet is captured and not fully sent.
REQ-015 SHALL have overrun  output  1  sticky: a mdr_ready was dropped.

Function
REQ-016 SHALL implement FSM states IDLE, HEADER, PAYLOAD; IDLE->HEADER on mdr_ready; HEADER->PAYLOAD on transfer if payload count nonzero, else ->IDLE; PAYLOAD->IDLE on transfer of the last word.
REQ-017 SHALL capture error, op, result and remainder into internal registers on the clock edge where mdr_ready is high and the packet is accepted; out_valid rises in the next cycle (latency 1).
REQ-018 SHALL define a transfer as out_valid && out_ready on a rising edge; out_data and out_last SHALL hold stable while out_valid && !out_ready.
REQ-019 SHALL emit the header word as: bit DW-1 = error, bits DW-2:DW-3 = op, bits 3:0 = payload word count, all other bits 0.
REQ-020 SHALL set payload count MULT=4... no: MULT=2 (result LSW, MSW), DIV=4 (quotient LSW, MSW, remainder LSW, MSW), ROOT=2 (result LSW, remainder LSW).
REQ-021 SHALL send a header-only packet (count 0, out_last=1 on header) when error=1 or op is the undefined code 2'b11.
REQ-022 SHALL assert out_last only on the final word of each packet.
REQ-023 SHALL accept a new mdr_ready in the same cycle as the final transfer of the current packet and go directly to HEADER with no idle bubble.
REQ-024 SHALL, on mdr_ready while busy and not in the final-transfer cycle, drop the new result, keep the current packet intact and set overrun.
REQ-025 SHALL clear overrun on clean; if clean and a drop occur in the same cycle, overrun SHALL be set.
REQ-026 SHALL drive busy high in HEADER and PAYLOAD, low in IDLE.

Reset
REQ-027 SHALL on rst low immediately force state IDLE, out_valid=0, out_last=0, out_data=0, busy=0, overrun=0, word counter=0 and capture registers=0.
REQ-028 SHALL abandon any partially sent packet on reset; no word of it is resent after release.

Structure
REQ-029 SHALL place reader state enum, header field bit positions and per-op payload counts in pkg_system_mdr alongside op_t and data_t.
REQ-030 SHALL be a single module; no sub-module required.

Verification
REQ-031 SHALL cover MULT 300*500: result 0x000249F0 -> words 0x0002, 0x49F0, 0x0002 (last).
REQ-032 SHALL cover DIV 1000/7: q=0x8E, r=6 -> 0x2004, 0x008E, 0x0000, 0x0006, 0x0000 (last).
REQ-033 SHALL cover ROOT 100 with out_ready low 3 cycles after first payload -> 0x4002, 0x000A held stable, 0x0000 (last).
REQ-034 SHALL cover DIV error=1 -> single word 0xA000 with out_last=1, busy low next cycle.
REQ-035 SHALL cover second mdr_ready during HEADER -> overrun=1, first packet unchanged; clean -> overrun=0; mdr_ready on final transfer -> next header next cycle, overrun stays 0.
REQ-036 SHALL cover rst low during PAYLOAD -> out_valid, busy 0 without waiting for a clock edge; next mdr_ready starts a fresh packet.
